// File: rtl/relu_maxpool_2x2.sv
// relu_maxpool_2x2: ReLU followed by 2x2 stride-2 max pooling on a raster
// ofmap stream. Top-row pair maxima are parked in a half-width register line
// buffer and merged with the bottom-row pair maxima to form each output.
// A frame whose length disagrees with the upstream end-of-frame pulse sets a
// sticky error flag.
module relu_maxpool_2x2 #(
  parameter int DATA_W = 16,
  parameter int OF_W   = 4,
  parameter int OF_H   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              conv_done,
  input  logic              clear,
  output logic [DATA_W-1:0] pool_out,
  output logic              pool_valid,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int COL_W = $clog2(OF_W);
  localparam int ROW_W = $clog2(OF_H);
  localparam int LB_N  = OF_W / 2;
  localparam int LB_W  = (LB_N > 1) ? $clog2(LB_N) : 1;

  typedef enum logic {
    ROW_TOP = 1'b0,
    ROW_BOT = 1'b1
  } row_state_e;

  // Unsigned maximum of two post-ReLU values.
  function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  row_state_e        state_r, state_nx;
  logic [COL_W-1:0]  col_r, col_nx;
  logic [ROW_W-1:0]  row_r, row_nx;
  logic [DATA_W-1:0] hold_r, hold_nx;
  logic [DATA_W-1:0] lbuf_r [LB_N];
  logic [DATA_W-1:0] lbuf_nx [LB_N];
  logic [DATA_W-1:0] pool_out_nx;
  logic              pool_valid_nx;
  logic              frame_done_nx;
  logic              frame_err_nx;

  logic [DATA_W-1:0] relu_s;
  logic [DATA_W-1:0] pm_s;
  logic [LB_W-1:0]   lb_idx_s;
  logic              col_last_s;
  logic              row_last_s;

  // Next-state, datapath and output computation; clear wins over everything,
  // a same-cycle sample is applied before any conv_done realignment.
  always_comb begin
    relu_s     = din[DATA_W-1] ? {DATA_W{1'b0}} : din;
    pm_s       = umax(hold_r, relu_s);
    lb_idx_s   = LB_W'(col_r >> 1);
    col_last_s = (col_r == COL_W'(OF_W - 1));
    row_last_s = (row_r == ROW_W'(OF_H - 1));

    state_nx      = state_r;
    col_nx        = col_r;
    row_nx        = row_r;
    hold_nx       = hold_r;
    lbuf_nx       = lbuf_r;
    pool_out_nx   = pool_out;
    pool_valid_nx = 1'b0;
    frame_done_nx = 1'b0;
    frame_err_nx  = frame_err;

    if (clear) begin
      state_nx     = ROW_TOP;
      col_nx       = {COL_W{1'b0}};
      row_nx       = {ROW_W{1'b0}};
      hold_nx      = {DATA_W{1'b0}};
      pool_out_nx  = {DATA_W{1'b0}};
      frame_err_nx = 1'b0;
      for (int i = 0; i < LB_N; i++) begin
        lbuf_nx[i] = {DATA_W{1'b0}};
      end
    end else begin
      if (din_valid) begin
        // Raster position advance; the row state tracks row parity.
        if (col_last_s) begin
          col_nx = {COL_W{1'b0}};
          if (row_last_s) begin
            row_nx = {ROW_W{1'b0}};
          end else begin
            row_nx = row_r + ROW_W'(1);
          end
          case (state_r)
            ROW_TOP: state_nx = ROW_BOT;
            ROW_BOT: state_nx = ROW_TOP;
            default: state_nx = ROW_TOP;
          endcase
        end else begin
          col_nx = col_r + COL_W'(1);
        end

        // Even column parks the sample; odd column closes a horizontal pair.
        if (col_r[0]) begin
          case (state_r)
            ROW_TOP: lbuf_nx[lb_idx_s] = pm_s;
            ROW_BOT: begin
              pool_out_nx   = umax(lbuf_r[lb_idx_s], pm_s);
              pool_valid_nx = 1'b1;
            end
            default: pool_valid_nx = 1'b0;
          endcase
        end else begin
          hold_nx = relu_s;
        end

        frame_done_nx = row_last_s & col_last_s;
      end else begin
        frame_done_nx = 1'b0;
      end

      if (conv_done) begin
        if ((col_nx != {COL_W{1'b0}}) || (row_nx != {ROW_W{1'b0}})) begin
          frame_err_nx = 1'b1;
        end else begin
          frame_err_nx = frame_err;
        end
        col_nx   = {COL_W{1'b0}};
        row_nx   = {ROW_W{1'b0}};
        state_nx = ROW_TOP;
      end else begin
        frame_err_nx = frame_err;
      end
    end
  end

  // Row-parity state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ROW_TOP;
    end else begin
      state_r <= state_nx;
    end
  end

  // Counters, pair holding register, line buffer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r      <= {COL_W{1'b0}};
      row_r      <= {ROW_W{1'b0}};
      hold_r     <= {DATA_W{1'b0}};
      pool_out   <= {DATA_W{1'b0}};
      pool_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      for (int i = 0; i < LB_N; i++) begin
        lbuf_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      col_r      <= col_nx;
      row_r      <= row_nx;
      hold_r     <= hold_nx;
      pool_out   <= pool_out_nx;
      pool_valid <= pool_valid_nx;
      frame_done <= frame_done_nx;
      frame_err  <= frame_err_nx;
      for (int i = 0; i < LB_N; i++) begin
        lbuf_r[i] <= lbuf_nx[i];
      end
    end
  end

endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// Scoreboard bench for relu_maxpool_2x2 (4x4 ofmap): expected window maxima
// are computed directly from the frame table when a window's last sample is
// driven, and popped when pool_valid appears.
module tb_relu_maxpool_2x2;

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  logic        din_valid;
  logic        conv_done;
  logic        clear;
  logic [15:0] pool_out;
  logic        pool_valid;
  logic        frame_done;
  logic        frame_err;

  relu_maxpool_2x2 #(.DATA_W(16), .OF_W(4), .OF_H(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .conv_done  (conv_done),
    .clear      (clear),
    .pool_out   (pool_out),
    .pool_valid (pool_valid),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  typedef struct {
    logic [15:0] val;
    logic        fd;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] fr [16];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [15:0] last_exp = 16'h0000;
  logic        hold_chk = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] relu(input logic [15:0] x);
    return x[15] ? 16'h0000 : x;
  endfunction

  function automatic logic [15:0] max2(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? a : b;
  endfunction

  task automatic drive(input logic [15:0] d, input logic v, input logic cd, input logic cl);
    @(posedge clk);
    #1;
    din       = d;
    din_valid = v;
    conv_done = cd;
    clear     = cl;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  // Stream the first n samples of fr; optional random gaps and a conv_done
  // pulse riding on sample cd_idx.
  task automatic run_frame(input int n, input int gap_pct, input int cd_idx);
    for (int i = 0; i < n; i++) begin
      while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) idle(1);
      drive(fr[i], 1'b1, (i == cd_idx), 1'b0);
      if (((i / 4) % 2 == 1) && ((i % 4) % 2 == 1)) begin
        exp_t e;
        e.val = max2(max2(relu(fr[i - 5]), relu(fr[i - 4])),
                     max2(relu(fr[i - 1]), relu(fr[i])));
        e.fd  = (i == 15);
        e.cyc = cyc + 1;
        sb.push_back(e);
      end
    end
    idle(3);
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pool_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", {31'd0, pool_valid}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("pool_out", {16'd0, pool_out}, {16'd0, e.val});
          check("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
          check("latency", cyc, e.cyc);
          last_exp = e.val;
        end
      end else begin
        if (frame_done) check("stray_frame_done", {31'd0, frame_done}, 32'd0);
        if (hold_chk) check("pool_out_hold", {16'd0, pool_out}, {16'd0, last_exp});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fr = '{16'h0001, 16'h0005, 16'hFFFD, 16'h0002,
           16'h0004, 16'hFFF9, 16'h0008, 16'h0000,
           16'h8000, 16'h8000, 16'h8000, 16'h8000,
           16'h8000, 16'h7FFF, 16'h8000, 16'h8000};
    rst_n = 1'b0; din = 16'h0000; din_valid = 1'b0; conv_done = 1'b0; clear = 1'b0;
    #12;
    check("rst_pool_out", {16'd0, pool_out}, 32'd0);
    check("rst_pool_valid", {31'd0, pool_valid}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hold_chk = 1'b1;

    // Basic pooling plus ReLU saturation rows: 5, 8, 0, 7FFF.
    run_frame(16, 0, -1);
    // Same frame with ~50% input gaps.
    run_frame(16, 50, -1);

    // Early conv_done after 10 samples.
    run_frame(10, 0, -1);
    drive(16'h0000, 1'b0, 1'b1, 1'b0);
    idle(2);
    check("early_err_set", {31'd0, frame_err}, 32'd1);
    run_frame(16, 0, -1);
    check("early_err_sticky", {31'd0, frame_err}, 32'd1);
    hold_chk = 1'b0;
    drive(16'h0000, 1'b0, 1'b0, 1'b1);
    idle(1);
    last_exp = 16'h0000;
    hold_chk = 1'b1;
    idle(1);
    check("clear_err", {31'd0, frame_err}, 32'd0);

    // conv_done aligned with the 16th sample.
    run_frame(16, 0, 15);
    check("aligned_no_err", {31'd0, frame_err}, 32'd0);

    // clear together with sample 7: that sample is dropped.
    run_frame(7, 0, -1);
    hold_chk = 1'b0;
    drive(fr[7], 1'b1, 1'b0, 1'b1);
    idle(1);
    last_exp = 16'h0000;
    hold_chk = 1'b1;
    run_frame(16, 0, -1);

    // Asynchronous reset mid-frame.
    run_frame(9, 0, -1);
    hold_chk = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_pool_out", {16'd0, pool_out}, 32'd0);
    check("mid_rst_pool_valid", {31'd0, pool_valid}, 32'd0);
    check("mid_rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_exp = 16'h0000;
    hold_chk = 1'b1;
    run_frame(16, 0, -1);

    idle(4);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
